gcd_ctrl: RTL and testbench



---
 rtl/gcd_ctrl_if.sv | 29 ++
 rtl/gcd_ctrl.sv | 103 ++++++++++
 tb/tb_gcd_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gcd_ctrl_if.sv
// Operand/result bus between the GCD controller and its environment.
// The controller uses the slave modport; the operand registers and requester use master.
interface gcd_ctrl_if #(
  parameter int unsigned W = 7
);
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] ta_q;
  logic [W-1:0] tb_q;
  logic         a_ld;
  logic         b_ld;
  logic [W-1:0] ta_in;
  logic [W-1:0] tb_in;
  logic         busy;
  logic         done;
  logic [W-1:0] gcd_out;
  logic [W-1:0] iter_cnt;

  modport master (
    output start, a_in, b_in, ta_q, tb_q,
    input  a_ld, b_ld, ta_in, tb_in, busy, done, gcd_out, iter_cnt
  );

  modport slave (
    input  start, a_in, b_in, ta_q, tb_q,
    output a_ld, b_ld, ta_in, tb_in, busy, done, gcd_out, iter_cnt
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Subtractive GCD sequencer driving external A/B operand registers.
// Define GCD_ITER_CNT_EN to implement the saturating subtraction counter on iter_cnt.
module gcd_ctrl #(
  parameter int unsigned W = 7
) (
  input  logic       clk,
  input  logic       rst,
  gcd_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] gcd_q, gcd_d;
`ifdef GCD_ITER_CNT_EN
  logic [W-1:0] iter_q, iter_d;
`endif

  // Next-state, operand-register control and result capture
  always_comb begin
    state_d   = state_q;
    gcd_d     = gcd_q;
    bus.a_ld  = 1'b0;
    bus.b_ld  = 1'b0;
    bus.ta_in = bus.ta_q;
    bus.tb_in = bus.tb_q;
`ifdef GCD_ITER_CNT_EN
    iter_d    = iter_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bus.a_ld  = 1'b1;
          bus.b_ld  = 1'b1;
          bus.ta_in = bus.a_in;
          bus.tb_in = bus.b_in;
`ifdef GCD_ITER_CNT_EN
          iter_d    = '0;
`endif
          state_d   = CMP;
        end
      end
      CMP: begin
        if ((bus.ta_q == '0) || (bus.tb_q == '0) || (bus.ta_q == bus.tb_q)) begin
          // A zero operand yields the other one; both zero yields zero
          gcd_d   = (bus.ta_q == '0) ? bus.tb_q : bus.ta_q;
          state_d = DONE;
        end else if (bus.ta_q > bus.tb_q) begin
          bus.a_ld  = 1'b1;
          bus.ta_in = bus.ta_q - bus.tb_q;
`ifdef GCD_ITER_CNT_EN
          iter_d    = (iter_q == '1) ? iter_q : iter_q + W'(1);
`endif
        end else begin
          bus.b_ld  = 1'b1;
          bus.tb_in = bus.tb_q - bus.ta_q;
`ifdef GCD_ITER_CNT_EN
          iter_d    = (iter_q == '1) ? iter_q : iter_q + W'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      gcd_q   <= gcd_d;
    end
  end

`ifdef GCD_ITER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign bus.iter_cnt = iter_q;
`else
  assign bus.iter_cnt = '0;
`endif

  assign bus.busy    = (state_q == CMP);
  assign bus.done    = (state_q == DONE);
  assign bus.gcd_out = gcd_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl with behavioural A/B operand registers.
// Expected iter_cnt follows GCD_ITER_CNT_EN as defined for the build.
module tb_gcd_ctrl;
  localparam int unsigned W = 7;

  logic clk;
  logic rst;
  logic [W-1:0] ta_r;
  logic [W-1:0] tb_r;

  int n_vec;
  int n_err;

  gcd_ctrl_if #(.W(W)) bus ();

  gcd_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand registers share the controller reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_r <= '0;
      tb_r <= '0;
    end else begin
      if (bus.a_ld) ta_r <= bus.ta_in;
      if (bus.b_ld) tb_r <= bus.tb_in;
    end
  end

  assign bus.ta_q = ta_r;
  assign bus.tb_q = tb_r;

  function automatic logic [31:0] exp_iter(input int n);
`ifdef GCD_ITER_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start in IDLE, check the load, and advance past the sampling edge
  task automatic do_start(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    #1;
    chk({tag, "_a_ld"}, 32'(bus.a_ld), 32'd1);
    chk({tag, "_ta_in"}, 32'(bus.ta_in), 32'(a));
    chk({tag, "_tb_in"}, 32'(bus.tb_in), 32'(b));
    step();
    bus.start = 1'b0;
    chk({tag, "_iter_clr"}, 32'(bus.iter_cnt), 32'd0);
  endtask

  // Wait (bounded) for done, check latency, busy span, result and pulse width
  task automatic wait_done(input string tag, input logic [W-1:0] exp_gcd, input int n_sub,
                           input bit start_in_done);
    int cyc;
    int busy_cnt;
    cyc      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 300) begin
      if (bus.busy === 1'b1) busy_cnt++;
      step();
      cyc++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(n_sub + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n_sub + 1));
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_gcd"}, 32'(bus.gcd_out), 32'(exp_gcd));
    chk({tag, "_iter"}, 32'(bus.iter_cnt), exp_iter(n_sub));
    if (start_in_done) begin
      bus.a_in  = 7'd5;
      bus.b_in  = 7'd3;
      bus.start = 1'b1;
    end
    step();
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_gcd_hold"}, 32'(bus.gcd_out), 32'(exp_gcd));
  endtask

  initial begin
    bit done_seen;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_gcd", 32'(bus.gcd_out), 32'd0);
    chk("rst_iter", 32'(bus.iter_cnt), 32'd0);
    chk("rst_a_ld", 32'(bus.a_ld), 32'd0);
    chk("rst_ta_in", 32'(bus.ta_in), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_b_ld", 32'(bus.b_ld), 32'd0);

    // 12,8: 12-8=4, 8-4=4
    do_start("g12_8", 7'd12, 7'd8);
    wait_done("g12_8", 7'd4, 2, 1'b0);

    // 127,1: 126 subtractions of B from A
    do_start("g127_1", 7'd127, 7'd1);
    wait_done("g127_1", 7'd1, 126, 1'b0);

    do_start("g0_9", 7'd0, 7'd9);
    wait_done("g0_9", 7'd9, 0, 1'b0);

    do_start("g0_0", 7'd0, 7'd0);
    wait_done("g0_0", 7'd0, 0, 1'b0);

    do_start("g17_17", 7'd17, 7'd17);
    chk("g17_17_no_a_ld", 32'(bus.a_ld), 32'd0);
    chk("g17_17_no_b_ld", 32'(bus.b_ld), 32'd0);
    wait_done("g17_17", 7'd17, 0, 1'b1);
    chk("done_start_ignored", 32'(bus.ta_q), 32'd17);

    // Starts during CMP must not disturb the running 12,8 computation
    do_start("mid", 7'd12, 7'd8);
    step();
    bus.a_in  = 7'd5;
    bus.b_in  = 7'd3;
    bus.start = 1'b1;
    #1;
    chk("mid_c2_a_ld", 32'(bus.a_ld), 32'd0);
    chk("mid_c2_tb_in", 32'(bus.tb_in), 32'd4);
    step();
    chk("mid_c3_b_ld", 32'(bus.b_ld), 32'd0);
    chk("mid_c3_ta_in", 32'(bus.ta_in), 32'd4);
    bus.start = 1'b0;
    step();
    chk("mid_done", 32'(bus.done), 32'd1);
    chk("mid_gcd", 32'(bus.gcd_out), 32'd4);
    step();
    chk("mid_done_pulse", 32'(bus.done), 32'd0);
    chk("mid_not_queued", 32'(bus.busy), 32'd0);

    // 5,3: 2,3 -> 2,1 -> 1,1
    do_start("g5_3", 7'd5, 7'd3);
    wait_done("g5_3", 7'd1, 3, 1'b0);

    // Reset in the middle of a long run
    do_start("rst_run", 7'd127, 7'd1);
    repeat (40) step();
    chk("rst_run_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_gcd", 32'(bus.gcd_out), 32'd0);
    chk("mid_rst_iter", 32'(bus.iter_cnt), 32'd0);
    chk("mid_rst_ta_q", 32'(bus.ta_q), 32'd0);
    step();
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (5) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    chk("mid_rst_quiet", 32'(done_seen), 32'd0);

    // 9,6: 3,6 -> 3,3
    do_start("g9_6", 7'd9, 7'd6);
    wait_done("g9_6", 7'd3, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
